// File: rtl/port_out_tx.sv
// ---------------------------------------------------------------------------
// port_out_tx
//
// Serial packet transmitter for one router link. A packet is taken over a
// parallel valid/ready handshake and sent on the frame_n / valid_n / dout
// lines as: one START cycle, four header cycles (address MSB first),
// PAD_CYCLES pad cycles, then the payload LSB first. frame_n rises in the
// cycle that carries the last payload bit.
//
// Handshake: a request is accepted at a rising clk edge where
// req_valid && req_ready. req_ready is high exactly when the block is idle.
// The request fields are copied on that edge, so the requester may change
// them immediately afterwards.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low
//   req_valid  request present
//   req_ready  block idle / request can be accepted
//   req_addr   4-bit destination port address
//   req_data   payload, bit 0 sent first
//   req_len    payload bit count 1..DATA_W, 0 encodes DATA_W
//   stall      pause payload; each edge in PAYLOAD decides gap or bit
//   frame_n    active-low frame (registered)
//   valid_n    active-low data valid (registered)
//   dout       serial data (registered)
//   busy       inverse of req_ready
//   done       one-cycle pulse in the first idle cycle after the last bit
// ---------------------------------------------------------------------------
module port_out_tx #(
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 6,
  parameter int PAD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              stall,
  output logic              frame_n,
  output logic              valid_n,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HEADER,
    S_PAD,
    S_PAYLOAD
  } state_t;

  localparam logic [3:0]       PAD_LAST = 4'(PAD_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DATA_W);

  state_t              state_q;
  logic [3:0]          addr_q;
  logic [1:0]          hdr_cnt_q;
  logic [3:0]          pad_cnt_q;
  logic [LEN_W-1:0]    bit_cnt_q;   // payload bits still to send
  logic [DATA_W-1:0]   shift_q;
  logic                frame_n_q;
  logic                valid_n_q;
  logic                dout_q;
  logic                done_q;

  logic                accept;
  logic                last_bit;

  // Outputs of the next payload cycle. The stall value seen at the edge
  // decides whether that cycle carries a bit or is a gap.
  logic                pay_frame_n_d;
  logic                pay_valid_n_d;
  logic                pay_dout_d;
  logic                pay_take_d;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;
  assign last_bit  = (bit_cnt_q == LEN_W'(1));

  assign frame_n   = frame_n_q;
  assign valid_n   = valid_n_q;
  assign dout      = dout_q;
  assign done      = done_q;

  always_comb begin
    pay_frame_n_d = 1'b0;
    pay_valid_n_d = 1'b1;
    pay_dout_d    = 1'b0;
    pay_take_d    = 1'b0;
    if (!stall) begin
      pay_take_d    = 1'b1;
      pay_valid_n_d = 1'b0;
      pay_dout_d    = shift_q[0];
      // End of frame is signalled in the same cycle as the last bit.
      pay_frame_n_d = last_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= 4'd0;
      hdr_cnt_q <= 2'd0;
      pad_cnt_q <= 4'd0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frame_n_q <= 1'b1;
      valid_n_q <= 1'b1;
      dout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q    <= req_addr;
            shift_q   <= req_data;
            bit_cnt_q <= (req_len == '0) ? LEN_FULL : req_len;
            state_q   <= S_START;
            frame_n_q <= 1'b0;
          end else begin
            frame_n_q <= 1'b1;
          end
          valid_n_q <= 1'b1;
          dout_q    <= 1'b0;
        end

        S_START: begin
          state_q   <= S_HEADER;
          hdr_cnt_q <= 2'd0;
          frame_n_q <= 1'b0;
          valid_n_q <= 1'b1;
          dout_q    <= addr_q[3];
        end

        S_HEADER: begin
          frame_n_q <= 1'b0;
          valid_n_q <= 1'b1;
          if (hdr_cnt_q == 2'd3) begin
            state_q   <= S_PAD;
            pad_cnt_q <= 4'd0;
            dout_q    <= 1'b0;
          end else begin
            // hdr_cnt_q counts header cycles already shown (addr[3] first).
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            dout_q    <= addr_q[2'd2 - hdr_cnt_q];
          end
        end

        S_PAD: begin
          if (pad_cnt_q == PAD_LAST) begin
            state_q   <= S_PAYLOAD;
            frame_n_q <= pay_frame_n_d;
            valid_n_q <= pay_valid_n_d;
            dout_q    <= pay_dout_d;
            if (pay_take_d) begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q - LEN_W'(1);
            end
          end else begin
            pad_cnt_q <= pad_cnt_q + 4'd1;
            frame_n_q <= 1'b0;
            valid_n_q <= 1'b1;
            dout_q    <= 1'b0;
          end
        end

        S_PAYLOAD: begin
          if (bit_cnt_q == '0) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            frame_n_q <= 1'b1;
            valid_n_q <= 1'b1;
            dout_q    <= 1'b0;
          end else begin
            frame_n_q <= pay_frame_n_d;
            valid_n_q <= pay_valid_n_d;
            dout_q    <= pay_dout_d;
            if (pay_take_d) begin
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q - LEN_W'(1);
            end
          end
        end

        default: begin
          state_q   <= S_IDLE;
          frame_n_q <= 1'b1;
          valid_n_q <= 1'b1;
          dout_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule
